// File: rtl/watch_disp_pkg.sv
// Shared display definitions: scan state, debug view, segment glyphs, blank code.
package watch_disp_pkg;

   // Scan phase of the anode multiplexer.
   typedef enum logic {
      SCAN_ON   = 1'b0,
      SCAN_DEAD = 1'b1
   } scan_state_t;

   // Debug view of the scan FSM, exported by the driver.
   typedef struct packed {
      scan_state_t state;
      logic [2:0]  slot;
   } scan_dbg_t;

   // All cathodes (or all anodes) off, active-low.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low gfedcba glyphs for hex digits; entry 15 listed first.
   localparam logic [15:0][6:0] SEG_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex digit to seven-segment cathode encoder (active-low).
module seg7_encode
   import watch_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dp_n,
   input  logic       enable,
   output logic [7:0] cathodes
);

   // Disabled digits go fully dark; the dp cathode follows dp_n directly.
   always_comb begin
      cathodes = SEG_BLANK;
      if (enable) begin
         cathodes = {dp_n, SEG_GLYPH[digit]};
      end
   end

endmodule

// File: rtl/watch_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver with dead-time between
// slots and a per-frame shadow capture of the digit codes.
module watch_scan_driver
   import watch_disp_pkg::*;
#(
   parameter int ON_CYCLES   = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_i,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   output logic [7:0] an_o,
   output logic [7:0] dec_cat_o,
   output scan_dbg_t  dbg_o
);

   localparam int CNT_MAX = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1)
                                                              : {CNT_W{1'b0}};

   scan_state_t       state_q, state_d;
   logic [2:0]        slot_q, slot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0][5:0]   shadow_q, shadow_d;
   logic [7:0][5:0]   d_all;
   logic              advance;
   logic [5:0]        code_d;
   logic [7:0]        enc_cat;
   logic [7:0]        an_d, cat_d;

   assign d_all = {d8, d7, d6, d5, d4, d3, d2, d1};

   // Next-state: ON/DEAD timing, slot advance and frame-start shadow capture.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      cnt_d    = cnt_q + CNT_W'(1);
      advance  = 1'b0;
      case (state_q)
         SCAN_ON: begin
            if (cnt_q == ON_LAST) begin
               cnt_d = '0;
               if (DEAD_CYCLES == 0) begin
                  advance = 1'b1;
               end else begin
                  state_d = SCAN_DEAD;
               end
            end
         end
         SCAN_DEAD: begin
            if (DEAD_CYCLES == 0 || cnt_q == DEAD_LAST) begin
               cnt_d   = '0;
               advance = 1'b1;
            end
         end
         default: begin
            state_d = SCAN_DEAD;
            cnt_d   = '0;
         end
      endcase
      if (advance) begin
         state_d = SCAN_ON;
         slot_d  = slot_q + 3'd1;
      end
      shadow_d = shadow_q;
      if (advance && slot_d == 3'd0) begin
         shadow_d = d_all;
      end
   end

   assign code_d = shadow_d[slot_d];

   seg7_encode u_seg7_encode (
      .digit    (code_d[4:1]),
      .dp_n     (code_d[0]),
      .enable   (code_d[5]),
      .cathodes (enc_cat)
   );

   // Output values for the state being entered, so pins change with the state.
   always_comb begin
      an_d  = SEG_BLANK;
      cat_d = SEG_BLANK;
      if (state_d == SCAN_ON) begin
         an_d  = ~(8'h01 << slot_d);
         cat_d = enc_cat;
      end
   end

   // State, shadow and output registers; reset blanks the display at once.
   always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= SCAN_DEAD;
         slot_q    <= 3'd7;
         cnt_q     <= '0;
         shadow_q  <= '0;
         an_o      <= SEG_BLANK;
         dec_cat_o <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         an_o      <= an_d;
         dec_cat_o <= cat_d;
      end
   end

   // Debug view of the scan FSM.
   always_comb begin
      dbg_o.state = state_q;
      dbg_o.slot  = slot_q;
   end

endmodule

// File: tb/tb_watch_scan_driver.sv
// Scoreboard bench: two drivers (ON=4/DEAD=2 and ON=4/DEAD=0) share inputs;
// a frame-arithmetic reference model predicts every cycle's outputs.
module tb_watch_scan_driver;
   import watch_disp_pkg::*;

   localparam int ON_A = 4, DEAD_A = 2, ON_B = 4, DEAD_B = 0;
   localparam int P_A = 8 * (ON_A + DEAD_A);
   localparam int P_B = 8 * (ON_B + DEAD_B);

   logic            clk_100MHz_i = 1'b0;
   logic            reset_i = 1'b0;
   logic [7:0][5:0] d_in;
   logic [7:0]      an_a, cat_a, an_b, cat_b;
   scan_dbg_t       dbg_a, dbg_b;

   int checks = 0;
   int errors = 0;
   int n = 0;          // rising edges since the last reset release
   bit running = 1'b0;

   logic [15:0]     exp_qa[$];
   logic [15:0]     exp_qb[$];
   logic [7:0][5:0] sh_a, sh_b;

   // monitor-side frame timing trackers
   int last_fe_a, last_fe_b, run_a, ff_b;
   bit have_fe_a, have_fe_b, seen_on_a;
   logic [7:0] prev_an_a, prev_an_b;

   watch_scan_driver #(.ON_CYCLES(ON_A), .DEAD_CYCLES(DEAD_A)) u_dut_a (
      .clk_100MHz_i (clk_100MHz_i), .reset_i (reset_i),
      .d1 (d_in[0]), .d2 (d_in[1]), .d3 (d_in[2]), .d4 (d_in[3]),
      .d5 (d_in[4]), .d6 (d_in[5]), .d7 (d_in[6]), .d8 (d_in[7]),
      .an_o (an_a), .dec_cat_o (cat_a), .dbg_o (dbg_a)
   );

   watch_scan_driver #(.ON_CYCLES(ON_B), .DEAD_CYCLES(DEAD_B)) u_dut_b (
      .clk_100MHz_i (clk_100MHz_i), .reset_i (reset_i),
      .d1 (d_in[0]), .d2 (d_in[1]), .d3 (d_in[2]), .d4 (d_in[3]),
      .d5 (d_in[4]), .d6 (d_in[5]), .d7 (d_in[6]), .d8 (d_in[7]),
      .an_o (an_b), .dec_cat_o (cat_b), .dbg_o (dbg_b)
   );

   // clock
   always #5 clk_100MHz_i = ~clk_100MHz_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // hex glyphs, active-low gfedcba
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // after reset, the leftover dead phase lasts DEAD cycles (at least one edge)
   function automatic int lead_in(input int dead_c);
      return (dead_c == 0) ? 1 : dead_c;
   endfunction

   function automatic bit frame_start(input int on_c, input int dead_c, input int nn);
      int lead;
      lead = lead_in(dead_c);
      return (nn >= lead) && (((nn - lead) % (8 * (on_c + dead_c))) == 0);
   endfunction

   // expected {an, cat} after edge nn, from frame position arithmetic
   function automatic logic [15:0] model_out(input int on_c, input int dead_c, input int nn,
                                             input logic [7:0][5:0] sh);
      int lead, u, q, slot, r;
      logic [5:0] code;
      logic [7:0] an, cat;
      lead = lead_in(dead_c);
      if (nn < lead) return 16'hFFFF;
      u    = nn - lead;
      q    = u % (8 * (on_c + dead_c));
      slot = q / (on_c + dead_c);
      r    = q % (on_c + dead_c);
      if (r >= on_c) return 16'hFFFF;
      code = sh[slot[2:0]];
      an   = 8'hFF;
      an[slot[2:0]] = 1'b0;
      cat  = code[5] ? {code[0], glyph(code[4:1])} : 8'hFF;
      return {an, cat};
   endfunction

   task automatic clear_mon();
      have_fe_a = 1'b0; have_fe_b = 1'b0; seen_on_a = 1'b0;
      run_a = 0; last_fe_a = 0; last_fe_b = 0;
      prev_an_a = 8'hFF; prev_an_b = 8'hFF;
      sh_a = '0; sh_b = '0;
   endtask

   // driver: one clock; snapshot inputs seen at the edge, push expectations
   task automatic step();
      logic [7:0][5:0] snap;
      @(posedge clk_100MHz_i);
      #1;
      n++;
      running = 1'b1;
      snap = d_in;
      if (frame_start(ON_A, DEAD_A, n)) sh_a = snap;
      if (frame_start(ON_B, DEAD_B, n)) sh_b = snap;
      exp_qa.push_back(model_out(ON_A, DEAD_A, n, sh_a));
      exp_qb.push_back(model_out(ON_B, DEAD_B, n, sh_b));
   endtask

   task automatic release_reset();
      @(posedge clk_100MHz_i);
      #1;
      reset_i = 1'b0;
      n = 0;
      clear_mon();
   endtask

   task automatic random_cycles(input int count);
      for (int i = 0; i < count; i++) begin
         step();
         if ($urandom_range(0, 3) == 0) d_in[$urandom_range(0, 7)] = 6'($urandom());
      end
   endtask

   // monitor: pops the scoreboard and tracks frame period / dead runs
   always @(negedge clk_100MHz_i) begin
      logic [15:0] e;
      if (exp_qa.size() > 0) begin
         e = exp_qa.pop_front();
         check("scan_a", {16'h0, an_a, cat_a}, {16'h0, e});
      end
      if (exp_qb.size() > 0) begin
         e = exp_qb.pop_front();
         check("scan_b", {16'h0, an_b, cat_b}, {16'h0, e});
      end
      if (running) begin
         if (an_a == 8'hFE && prev_an_a != 8'hFE) begin
            if (have_fe_a) check("period_a", n - last_fe_a, P_A);
            last_fe_a = n;
            have_fe_a = 1'b1;
         end
         if (an_a == 8'hFF) begin
            run_a++;
         end else begin
            if (seen_on_a && run_a > 0) check("dead_run_a", run_a, DEAD_A);
            run_a = 0;
            seen_on_a = 1'b1;
         end
         if (an_b == 8'hFE && prev_an_b != 8'hFE) begin
            if (have_fe_b) check("period_b", n - last_fe_b, P_B);
            last_fe_b = n;
            have_fe_b = 1'b1;
         end
         if (an_b == 8'hFF) ff_b++;
         prev_an_a = an_a;
         prev_an_b = an_b;
      end
   end

   // stimulus
   initial begin
      bit found;
      ff_b = 0;
      clear_mon();
      d_in    = '0;
      d_in[0] = 6'b100001;   // 0, dp dark
      d_in[1] = 6'b100100;   // 2, dp lit
      d_in[2] = 6'b110101;   // A
      d_in[3] = 6'b100111;   // 3
      d_in[4] = 6'b111110;   // F, dp lit
      d_in[5] = 6'b000001;   // disabled
      d_in[6] = 6'b101011;   // 5
      d_in[7] = 6'b110001;   // 8

      // reset held: display blank
      #1 reset_i = 1'b1;
      repeat (3) begin
         @(posedge clk_100MHz_i);
         #1;
         check("reset_an_a", {24'h0, an_a}, 32'hFF);
         check("reset_cat_a", {24'h0, cat_a}, 32'hFF);
         check("reset_an_b", {24'h0, an_b}, 32'hFF);
      end
      release_reset();

      // two directed frames; d4 changes to 7 during slot 2 of the first frame
      for (int i = 0; i < 2 * P_A + 4; i++) begin
         step();
         if (n == DEAD_A + 2 * (ON_A + DEAD_A) + 1) d_in[3] = 6'b101111;
      end

      random_cycles(6 * P_A);

      // advance to slot 4 ON of driver A, then reset between edges
      found = 1'b0;
      for (int i = 0; i < 2 * P_A && !found; i++) begin
         step();
         if (n >= DEAD_A && (((n - DEAD_A) % P_A) / (ON_A + DEAD_A)) == 4 &&
             ((n - DEAD_A) % (ON_A + DEAD_A)) == 1) found = 1'b1;
      end
      check("reach_slot4", {31'h0, found}, 32'h1);
      check("slot4_an_pre", {24'h0, an_a}, 32'hEF);
      #2;
      exp_qa.delete();
      exp_qb.delete();
      running = 1'b0;
      reset_i = 1'b1;
      #1;
      check("async_an_a", {24'h0, an_a}, 32'hFF);
      check("async_cat_a", {24'h0, cat_a}, 32'hFF);
      check("async_an_b", {24'h0, an_b}, 32'hFF);
      check("async_cat_b", {24'h0, cat_b}, 32'hFF);
      repeat (2) @(posedge clk_100MHz_i);
      #1;
      check("reset_hold_an_a", {24'h0, an_a}, 32'hFF);
      release_reset();

      random_cycles(3 * P_A);

      @(negedge clk_100MHz_i);
      #1;
      check("queue_a_drained", exp_qa.size(), 0);
      check("queue_b_drained", exp_qb.size(), 0);
      check("ff_anode_b", ff_b, 0);
      check("period_a_seen", {31'h0, have_fe_a}, 32'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/watch_scan_driver.md
WATCH_SCAN_DRIVER -- requirements
Module: watch_scan_driver

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 100000, meaning clock cycles each digit anode is lit (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter DEAD_CYCLES, default 1000, meaning all-anodes-off cycles between digit slots (anti-ghosting).
REQ-003 SHALL have port clk_100MHz_i  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports d1..d8  input  6 each  digit codes {enable[5], digit[4:1], dp_n[0]}; d1 rightmost, d8 leftmost.
REQ-006 SHALL have port an_o  output  8  anode selects, active-low; an_o[k] drives the position of d(k+1).
REQ-007 SHALL have port dec_cat_o  output  8  cathodes {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-008 SHALL scan slots 0..7 (slot k shows d(k+1)) cyclically; each slot is ON for ON_CYCLES cycles, then DEAD for DEAD_CYCLES cycles.
REQ-009 SHALL use a two-state machine SCAN_ON / SCAN_DEAD with a cycle counter sized for max(ON_CYCLES, DEAD_CYCLES); SCAN_ON -> SCAN_DEAD when the counter reaches ON_CYCLES-1; SCAN_DEAD -> SCAN_ON when it reaches DEAD_CYCLES-1, advancing the slot index mod 8 (7 wraps to 0).
REQ-010 SHALL, when DEAD_CYCLES = 0, skip SCAN_DEAD and advance directly from SCAN_ON to the next slot's SCAN_ON.
REQ-011 SHALL capture all eight d1..d8 codes into a shadow register on the edge that enters slot 0's SCAN_ON; slots 0..7 of that frame display only shadow values (no tearing from mid-frame input changes).
REQ-012 SHALL drive registered outputs: in SCAN_ON of slot k, an_o = ~(8'h01 << k); in SCAN_DEAD, an_o = 8'hFF and dec_cat_o = 8'hFF.
REQ-013 SHALL encode digit[4:1] 0-F to hex glyphs 0-9, A, b, C, d, E, F (active-low gfedcba; 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00), dp cathode = dp_n bit directly (1 = dark).
REQ-014 SHALL, for a slot whose shadow enable bit is 0, keep the anode asserted and force dec_cat_o = 8'hFF (digit and dp dark).
REQ-015 SHALL have outputs change only on clock edges, one register stage after state/index, with no combinational path from d1..d8 to outputs.
REQ-016 SHALL give a frame period of exactly 8*(ON_CYCLES+DEAD_CYCLES) cycles.

Reset
REQ-017 SHALL, while reset_i is high, immediately (without a clock edge) force an_o = 8'hFF, dec_cat_o = 8'hFF, shadow = all zeros, state = SCAN_DEAD, slot index = 7, counter = 0.
REQ-018 SHALL, after reset release, complete the DEAD phase (DEAD_CYCLES cycles, or zero) then enter slot 0 SCAN_ON with a fresh shadow capture.
REQ-019 SHALL treat reset asserted mid-slot identically to power-on reset; no partial-slot continuation.

Structure
REQ-020 SHALL place the scan state typedef, the 16-entry segment glyph table and the blank constant 8'hFF in shared package watch_disp_pkg.
REQ-021 SHALL instantiate one combinational sub-module seg7_encode (4-bit digit + dp_n + enable -> 8-bit cathodes), reusable by other display blocks.

Verification
REQ-022 SHALL cover (ON_CYCLES=4, DEAD_CYCLES=2): hold reset -> an_o=8'hFF, dec_cat_o=8'hFF; release -> 2 cycles all-off, then an_o=8'hFE for exactly 4 cycles.
REQ-023 SHALL cover: d1=6'b100001, d8=6'b110001 -> slot 0 dec_cat_o=8'hC0 with an_o=8'hFE; slot 7 dec_cat_o=8'h80 with an_o=8'h7F.
REQ-024 SHALL cover: d6=6'b000001 (enable 0) -> slot 5 an_o=8'hDF, dec_cat_o=8'hFF.
REQ-025 SHALL cover: change d4 from digit 3 to digit 7 during slot 2 -> slot 3 shows 8'hB0 this frame, 8'hF8 next frame.
REQ-026 SHALL cover: frame period 48 cycles with exactly 2 all-off cycles between slots; DEAD_CYCLES=0 rerun -> period 32, no 8'hFF anode cycles.
REQ-027 SHALL cover: assert reset_i asynchronously mid-slot 4 -> an_o and dec_cat_o become 8'hFF before the next clock edge; restart per REQ-018.
